// File: rtl/bcd2bin16_seq.sv
// bcd2bin16_seq
// -----------------------------------------------------------------------------
// Multi-cycle packed-BCD to binary converter (reverse double-dabble).
// A packed BCD value is accepted with a valid/ready handshake and converted
// one bit per clock. The 16-bit result is presented with its own
// valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   bcd_in holds a value to convert
//   in_ready   block can accept a value (high only while idle)
//   bcd_in     packed BCD, most significant digit in the top nibble
//   out_valid  binary/overflow/bad_digit are valid (high only when done)
//   out_ready  consumer takes the result
//   binary     converted value
//   overflow   full converted value does not fit in OUT_W bits
//   bad_digit  at least one input nibble was greater than 9
//
// Build option:
//   BCD2BIN_SAT_EN  when defined, an overflowing result saturates binary to
//                   all ones; otherwise binary carries the truncated low bits.
module bcd2bin16_seq #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17,
    parameter int OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      binary,
    output logic                  overflow,
    output logic                  bad_digit
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_corr;
    logic [CNT_W-1:0]   cnt;
    logic               bad_latch;
    logic               last_iter;
    logic [BIN_W-1:0]   bin_next;
    logic               ovf_next;
    logic [OUT_W-1:0]   res_bin;
    logic               res_ovf;

    // Any nibble above 9 marks the whole input as malformed.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    // One reverse double-dabble step: shift the whole {bcd, bin} register
    // right, then pull every BCD digit that landed at 8 or more back down
    // by 3. This undoes the "add 3 if >= 5" of the forward algorithm, so
    // each digit halves correctly in decimal.
    always_comb begin
        sr_shift = sr >> 1;
        sr_corr  = sr_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_corr[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Result fields as they will look after the final iteration. A bad
    // input digit overrides everything else.
    assign bin_next = sr_corr[BIN_W-1:0];
    assign ovf_next = |bin_next[BIN_W-1:OUT_W];

    always_comb begin
`ifdef BCD2BIN_SAT_EN
        res_bin = ovf_next ? {OUT_W{1'b1}} : bin_next[OUT_W-1:0];
`else
        res_bin = bin_next[OUT_W-1:0];
`endif
        res_ovf = ovf_next;
        if (bad_latch) begin
            res_bin = '0;
            res_ovf = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> CONV -> DONE -> IDLE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load on accept, iterate during conversion, and capture the
    // result fields only on the edge that enters DONE so they stay frozen
    // until the next conversion finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            bad_latch <= 1'b0;
            binary    <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr        <= {bcd_in, {BIN_W{1'b0}}};
                        cnt       <= '0;
                        bad_latch <= has_bad_digit(bcd_in);
                    end
                end
                CONV: begin
                    sr  <= sr_corr;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        binary    <= res_bin;
                        overflow  <= res_ovf;
                        bad_digit <= bad_latch;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
